gshare_predictor_param: RTL and testbench
=========================================

GSHARE_PREDICTOR_PARAM -- requirements
Module: gshare_predictor_param

Interface
REQ-001 SHALL have parameter GHR_LEN, default 8: global history length in bits, range 1..32.
REQ-002 SHALL have parameter PHT_DEPTH_LOG2, default 10: log2 of PHT entry count, range 2..14.
REQ-003 SHALL have parameter CTR_WIDTH, default 2: saturating counter width, range 1..4.
REQ-004 SHALL have parameter INFLIGHT_DEPTH, default 4: in-flight queue entries, power of two, 2..16.
REQ-005 SHALL have port clk, in, 1: sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, in, 1: synchronous, active-high reset.
REQ-007 SHALL have port query_valid, in, 1: prediction request.
REQ-008 SHALL have port query_ready, out, 1: request accepted when query_valid && query_ready.
REQ-009 SHALL have port query_pc, in, 32: branch PC.
REQ-010 SHALL have port query_taken, out, 1: combinational prediction for query_pc.
REQ-011 SHALL have port update_valid, in, 1: resolution of the oldest in-flight branch.
REQ-012 SHALL have port update_taken, in, 1: actual direction.
REQ-013 SHALL have port mispredict_o, out, 1: registered one-cycle pulse after a mispredicting update.
REQ-014 SHALL have port ghr_o, out, GHR_LEN: current speculative GHR.
REQ-015 SHALL have ports perf_query_cnt and perf_mispred_cnt, out, 32 each: performance counters.

Function
REQ-016 Index SHALL be fold(GHR) XOR query_pc[PHT_DEPTH_LOG2+1:2], where fold XORs successive PHT_DEPTH_LOG2-bit chunks of the GHR, zero-padding the last chunk.
REQ-017 query_taken SHALL equal the MSB of PHT[index], using the pre-write value when an update writes the same entry in the same cycle.
REQ-018 On accept, the GHR SHALL become {GHR[GHR_LEN-2:0], query_taken}; for GHR_LEN=1 it SHALL become query_taken.
REQ-019 On accept, {index, query_taken, pre-shift GHR} SHALL be pushed to the in-flight FIFO.
REQ-020 query_ready SHALL equal (state==READY) && (!full || update_valid) && !(update_valid && mispredict), where mispredict is the combinational compare of update_taken with the head entry's stored prediction.
REQ-021 An update with a non-empty FIFO SHALL pop the head and step PHT[head.index]: +1 if taken, -1 if not, saturating at 0 and 2^CTR_WIDTH-1.
REQ-022 An update with an empty FIFO SHALL be ignored, with no PHT, GHR or counter change.
REQ-023 On a mispredicting update, the FIFO SHALL be flushed, and the GHR SHALL be set to {head.ghr[GHR_LEN-2:0], update_taken} (update_taken alone for GHR_LEN=1) on the same edge.
REQ-024 On a mispredicting update, mispredict_o SHALL pulse on the following cycle.
REQ-025 A correct update and an accepted query in the same cycle SHALL pop and push together, leaving occupancy unchanged, and SHALL be allowed when the FIFO is full.
REQ-026 FSM states SHALL be INIT and READY.
REQ-027 In INIT, a counter SHALL write 2^(CTR_WIDTH-1)-1 (weakly not-taken) to one PHT entry per cycle, from 0 up to 2^PHT_DEPTH_LOG2-1, then go to READY.
REQ-028 In INIT, updates SHALL be ignored and query_ready SHALL be 0.

Reset
REQ-029 When rst is asserted, the block SHALL enter INIT with init counter 0, GHR 0, FIFO empty, mispredict_o 0 and perf counters 0.
REQ-030 Assertion of rst mid-operation, including mid-INIT, SHALL restart the full PHT sweep.
REQ-031 The PHT SHALL have no reset beyond the INIT sweep.

Configuration
REQ-032 With GSHARE_PERF_CNT_EN defined, perf_query_cnt SHALL count accepted queries and perf_mispred_cnt SHALL count mispredicting updates, each saturating at 32'hFFFFFFFF.
REQ-033 With GSHARE_PERF_CNT_EN undefined, both perf outputs SHALL be constant 0 and the counters SHALL not be built.

Verification
REQ-034 Bench SHALL cover init: release rst with defaults -> query_ready=0 for exactly 1024 cycles, then 1; first query at any PC -> query_taken=0.
REQ-035 Bench SHALL cover training: repeat query_pc=0x1000 with update_taken=1 and GHR held at 0 (restored each time) -> entry counts 1->2 and query_taken=1 from the second query; further updates saturate at 3.
REQ-036 Bench SHALL cover FIFO full: 4 queries with no update -> query_ready=0; same-cycle correct update plus query -> accepted, occupancy stays 4.
REQ-037 Bench SHALL cover mispredict: queries A(pred 0), B, C in flight, update_taken=1 -> FIFO empty, ghr_o={A.ghr[6:0],1}, mispredict_o=1 on the next cycle, query_ready=0 during the update cycle.
REQ-038 Bench SHALL cover an empty-FIFO update: update_valid=1 with FIFO empty -> no PHT, GHR or perf change.
REQ-039 Bench SHALL cover perf counters: 10 queries with 3 mispredicts and macro defined -> counts 10/3; macro undefined -> 0/0.

Source files
------------

// File: rtl/gshare_predictor_param.sv
// gshare_predictor_param: gshare branch direction predictor.
// A pattern history table of saturating counters is indexed by the folded
// speculative global history XOR the branch PC. Each accepted query is
// remembered in an in-flight FIFO until its resolution arrives (in order);
// a wrong resolution flushes the FIFO and repairs the history.
// Optional feature macro: GSHARE_PERF_CNT_EN builds the query/mispredict
// performance counters; without it both perf outputs are tied to zero.
//
// Handshake: a query is accepted on a rising edge where query_valid and
// query_ready are both 1; query_ready never depends on query_valid. The
// update port has no ready: update_valid=1 always resolves the oldest
// in-flight branch, and is ignored when nothing is in flight or in INIT.
module gshare_predictor_param #(
    parameter int GHR_LEN        = 8,
    parameter int PHT_DEPTH_LOG2 = 10,
    parameter int CTR_WIDTH      = 2,
    parameter int INFLIGHT_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              query_valid,
    output logic                              query_ready,
    input  logic [31:0]                       query_pc,
    output logic                              query_taken,
    input  logic                              update_valid,
    input  logic                              update_taken,
    output logic                              mispredict_o,
    output logic [GHR_LEN-1:0]                ghr_o,
    output logic [31:0]                       perf_query_cnt,
    output logic [31:0]                       perf_mispred_cnt,
    output logic                              state_o,
    output logic [$clog2(INFLIGHT_DEPTH):0]   fifo_count_o
);

    localparam int IDX_W     = PHT_DEPTH_LOG2;
    localparam int PHT_DEPTH = 1 << IDX_W;
    localparam int PTR_W     = $clog2(INFLIGHT_DEPTH);

    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = CTR_WIDTH'((1 << CTR_WIDTH) - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_ONE  = CTR_WIDTH'(1);
    localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
    localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]       CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]       CNT_FULL = (PTR_W + 1)'(INFLIGHT_DEPTH);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // State registers
    logic [0:0]         state_q, state_d;
    logic [IDX_W-1:0]   init_cnt_q, init_cnt_d;
    logic [GHR_LEN-1:0] ghr_q, ghr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               mispredict_q, mispredict_d;

    // Storage without reset: PHT is swept in INIT, FIFO slots are written before use
    logic [CTR_WIDTH-1:0] pht_q       [PHT_DEPTH];
    logic [IDX_W-1:0]     fifo_idx_q  [INFLIGHT_DEPTH];
    logic                 fifo_pred_q [INFLIGHT_DEPTH];
    logic [GHR_LEN-1:0]   fifo_ghr_q  [INFLIGHT_DEPTH];

    logic [IDX_W-1:0]     fold_idx;
    logic [IDX_W-1:0]     query_idx;
    logic                 in_ready;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [IDX_W-1:0]     head_idx;
    logic                 head_pred;
    logic [GHR_LEN-1:0]   head_ghr;
    logic [CTR_WIDTH-1:0] head_ctr;
    logic [CTR_WIDTH-1:0] ctr_next;
    logic                 upd_fire;
    logic                 mispredict;
    logic                 accept;
    logic                 pht_we;
    logic [IDX_W-1:0]     pht_waddr;
    logic [CTR_WIDTH-1:0] pht_wdata;
    logic                 unused_pc;

    // Only the index bits of the PC take part in the lookup
    assign unused_pc = ^{query_pc[31:IDX_W+2], query_pc[1:0]};

    // Fold the history into IDX_W bits; the last chunk is implicitly zero-padded
    always_comb begin
        fold_idx = '0;
        for (int i = 0; i < GHR_LEN; i++) begin
            fold_idx[i % IDX_W] = fold_idx[i % IDX_W] ^ ghr_q[i];
        end
    end

    assign query_idx   = fold_idx ^ query_pc[IDX_W+1:2];
    // Array read returns the pre-write value when an update hits the same entry
    assign query_taken = pht_q[query_idx][CTR_WIDTH-1];

    assign in_ready   = (state_q == ST_READY);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);
    assign head_idx   = fifo_idx_q[rd_ptr_q];
    assign head_pred  = fifo_pred_q[rd_ptr_q];
    assign head_ghr   = fifo_ghr_q[rd_ptr_q];
    assign head_ctr   = pht_q[head_idx];

    assign upd_fire    = in_ready && update_valid && !fifo_empty;
    assign mispredict  = upd_fire && (update_taken != head_pred);
    // A full FIFO can still accept when a resolution frees the head slot this cycle
    assign query_ready = in_ready && (!fifo_full || update_valid) && !mispredict;
    assign accept      = query_valid && query_ready;

    // Saturating step of the resolved branch's counter
    always_comb begin
        ctr_next = head_ctr;
        if (update_taken) begin
            if (head_ctr != CTR_MAX) ctr_next = head_ctr + CTR_ONE;
        end else begin
            if (head_ctr != '0) ctr_next = head_ctr - CTR_ONE;
        end
    end

    // PHT write port: INIT sweep or counter training
    always_comb begin
        pht_we    = 1'b0;
        pht_waddr = init_cnt_q;
        pht_wdata = CTR_INIT;
        if (state_q == ST_INIT) begin
            pht_we = 1'b1;
        end else if (upd_fire) begin
            pht_we    = 1'b1;
            pht_waddr = head_idx;
            pht_wdata = ctr_next;
        end
    end

    // Next-state logic for FSM, history and FIFO pointers
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        ghr_d        = ghr_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        mispredict_d = mispredict;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + IDX_ONE;
            if (init_cnt_q == '1) state_d = ST_READY;
        end else if (mispredict) begin
            // Flush everything younger and rebuild history from the head's snapshot
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            ghr_d    = (head_ghr << 1) | GHR_LEN'(update_taken);
        end else begin
            if (accept) begin
                ghr_d    = (ghr_q << 1) | GHR_LEN'(query_taken);
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (upd_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (accept && !upd_fire) count_d = count_q + CNT_ONE;
            else if (!accept && upd_fire) count_d = count_q - CNT_ONE;
        end
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            ghr_q        <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            mispredict_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            ghr_q        <= ghr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            mispredict_q <= mispredict_d;
        end
    end

    // PHT storage
    always_ff @(posedge clk) begin
        if (pht_we) pht_q[pht_waddr] <= pht_wdata;
    end

    // In-flight FIFO payload: lookup index, prediction, pre-shift history
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_idx_q[wr_ptr_q]  <= query_idx;
            fifo_pred_q[wr_ptr_q] <= query_taken;
            fifo_ghr_q[wr_ptr_q]  <= ghr_q;
        end
    end

`ifdef GSHARE_PERF_CNT_EN
    logic [31:0] perf_query_q;
    logic [31:0] perf_mispred_q;

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_query_q   <= '0;
            perf_mispred_q <= '0;
        end else begin
            if (accept && (perf_query_q != 32'hFFFF_FFFF)) perf_query_q <= perf_query_q + 32'd1;
            if (mispredict && (perf_mispred_q != 32'hFFFF_FFFF)) perf_mispred_q <= perf_mispred_q + 32'd1;
        end
    end

    assign perf_query_cnt   = perf_query_q;
    assign perf_mispred_cnt = perf_mispred_q;
`else
    assign perf_query_cnt   = 32'd0;
    assign perf_mispred_cnt = 32'd0;
`endif

    assign mispredict_o = mispredict_q;
    assign ghr_o        = ghr_q;
    assign state_o      = state_q;
    assign fifo_count_o = count_q;

endmodule

// File: tb/tb_gshare_predictor_param.sv
// Directed bench for gshare_predictor_param with default parameters
// (GHR 8 bits, 1024-entry PHT, 2-bit counters, 4 in-flight entries).
module tb_gshare_predictor_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        query_valid;
    logic        query_ready;
    logic [31:0] query_pc;
    logic        query_taken;
    logic        update_valid;
    logic        update_taken;
    logic        mispredict_o;
    logic [7:0]  ghr_o;
    logic [31:0] perf_query_cnt;
    logic [31:0] perf_mispred_cnt;
    logic        state_o;
    logic [2:0]  fifo_count_o;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic        exp_pred;
        logic        exp_mis;
        logic        empty_upd;
    } train_vec_t;

    train_vec_t tv [11];

    gshare_predictor_param dut (
        .clk              (clk),
        .rst              (rst),
        .query_valid      (query_valid),
        .query_ready      (query_ready),
        .query_pc         (query_pc),
        .query_taken      (query_taken),
        .update_valid     (update_valid),
        .update_taken     (update_taken),
        .mispredict_o     (mispredict_o),
        .ghr_o            (ghr_o),
        .perf_query_cnt   (perf_query_cnt),
        .perf_mispred_cnt (perf_mispred_cnt),
        .state_o          (state_o),
        .fifo_count_o     (fifo_count_o)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles with query_ready low, bounded
    task automatic wait_ready(input int exp_low, input string tag);
        int low = 0;
        while (query_ready !== 1'b1 && low < 3000) begin
            low++;
            tick();
        end
        check({tag, "_ready_up"}, {31'd0, query_ready}, 32'd1);
        check({tag, "_init_len"}, low, exp_low);
    endtask

    task automatic do_query(input logic [31:0] pc, input logic exp_pred, input string tag);
        query_valid = 1'b1;
        query_pc    = pc;
        #1;
        check({tag, "_ready"}, {31'd0, query_ready}, 32'd1);
        check({tag, "_pred"}, {31'd0, query_taken}, {31'd0, exp_pred});
        tick();
        query_valid = 1'b0;
    endtask

    task automatic do_update(input logic taken, input logic exp_mis, input string tag);
        update_valid = 1'b1;
        update_taken = taken;
        #1;
        if (exp_mis) check({tag, "_ready_low"}, {31'd0, query_ready}, 32'd0);
        tick();
        update_valid = 1'b0;
        check({tag, "_mis"}, {31'd0, mispredict_o}, {31'd0, exp_mis});
    endtask

    // Walk GHR from 0x01 back to 0 by shifting in eight not-taken predictions
    task automatic restore_ghr();
        for (int k = 0; k < 8; k++) begin
            do_query(32'h0000_0C00, 1'b0, "restore_q");
            do_update(1'b0, 1'b0, "restore_u");
        end
        check("restore_ghr", {24'd0, ghr_o}, 32'd0);
    endtask

    initial begin
        // pc 0x1000 -> index 0 while GHR is 0; counter starts at 1
        tv[0]  = '{32'h1000, 1'b1, 1'b0, 1'b1, 1'b0};  // 1 -> 2
        tv[1]  = '{32'h1000, 1'b1, 1'b1, 1'b0, 1'b0};  // 2 -> 3
        tv[2]  = '{32'h1000, 1'b1, 1'b1, 1'b0, 1'b0};  // 3 sat
        tv[3]  = '{32'h1000, 1'b1, 1'b1, 1'b0, 1'b1};  // 3 sat, then empty update
        tv[4]  = '{32'h1000, 1'b0, 1'b1, 1'b1, 1'b0};  // 3 -> 2
        tv[5]  = '{32'h1000, 1'b0, 1'b1, 1'b1, 1'b0};  // 2 -> 1
        tv[6]  = '{32'h1000, 1'b0, 1'b0, 1'b0, 1'b0};  // 1 -> 0
        tv[7]  = '{32'h1000, 1'b0, 1'b0, 1'b0, 1'b0};  // 0 sat
        tv[8]  = '{32'h1000, 1'b1, 1'b0, 1'b1, 1'b0};  // 0 -> 1
        tv[9]  = '{32'h1000, 1'b1, 1'b0, 1'b1, 1'b0};  // 1 -> 2
        tv[10] = '{32'h1000, 1'b0, 1'b1, 1'b1, 1'b0};  // 2 -> 1

        rst          = 1'b1;
        query_valid  = 1'b0;
        query_pc     = 32'd0;
        update_valid = 1'b0;
        update_taken = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_ready", {31'd0, query_ready}, 32'd0);
        check("rst_state", {31'd0, state_o}, 32'd0);
        check("rst_ghr", {24'd0, ghr_o}, 32'd0);
        check("rst_mis", {31'd0, mispredict_o}, 32'd0);
        check("rst_fifo", {29'd0, fifo_count_o}, 32'd0);
        check("rst_perf_q", perf_query_cnt, 32'd0);
        check("rst_perf_m", perf_mispred_cnt, 32'd0);

        // Reset in the middle of INIT restarts the whole sweep
        rst = 1'b0;
        repeat (300) tick();
        check("midinit_state", {31'd0, state_o}, 32'd0);
        rst = 1'b1;
        repeat (2) tick();
        check("midinit_rst_ready", {31'd0, query_ready}, 32'd0);
        rst = 1'b0;
        wait_ready(1024, "init1");

        // First prediction after INIT is weakly not-taken
        query_pc = 32'h0000_1234;
        #1;
        check("first_pred", {31'd0, query_taken}, 32'd0);

        // Training at a fixed entry with GHR held at 0
        for (int i = 0; i < 11; i++) begin
            check($sformatf("train%0d_ghr_pre", i), {24'd0, ghr_o}, 32'd0);
            do_query(tv[i].pc, tv[i].exp_pred, $sformatf("train%0d", i));
            do_update(tv[i].taken, tv[i].exp_mis, $sformatf("train%0d", i));
            check($sformatf("train%0d_ghr", i), {24'd0, ghr_o}, {31'd0, tv[i].taken});
            check($sformatf("train%0d_fifo", i), {29'd0, fifo_count_o}, 32'd0);
            if (tv[i].empty_upd) begin
                // Stale head slot holds idx 0 / pred 1: must not be resolved
                update_valid = 1'b1;
                update_taken = 1'b0;
                tick();
                update_valid = 1'b0;
                check("empty_upd_ghr", {24'd0, ghr_o}, 32'h01);
                check("empty_upd_fifo", {29'd0, fifo_count_o}, 32'd0);
                check("empty_upd_mis", {31'd0, mispredict_o}, 32'd0);
            end
            if (tv[i].taken) restore_ghr();
        end

        // FIFO full: four queries, blocked fifth, then pop+push in one cycle
        do_query(32'h40, 1'b0, "full_a");
        do_query(32'h44, 1'b0, "full_b");
        do_query(32'h48, 1'b0, "full_c");
        do_query(32'h4C, 1'b0, "full_d");
        check("full_count", {29'd0, fifo_count_o}, 32'd4);
        query_valid = 1'b1;
        query_pc    = 32'h50;
        #1;
        check("full_block", {31'd0, query_ready}, 32'd0);
        tick();
        check("full_block_count", {29'd0, fifo_count_o}, 32'd4);
        update_valid = 1'b1;
        update_taken = 1'b0;
        #1;
        check("full_swap_ready", {31'd0, query_ready}, 32'd1);
        check("full_swap_pred", {31'd0, query_taken}, 32'd0);
        tick();
        query_valid  = 1'b0;
        update_valid = 1'b0;
        check("full_swap_count", {29'd0, fifo_count_o}, 32'd4);
        check("full_swap_mis", {31'd0, mispredict_o}, 32'd0);
        for (int k = 0; k < 4; k++) do_update(1'b0, 1'b0, "drain");
        check("drain_count", {29'd0, fifo_count_o}, 32'd0);
        check("drain_ghr", {24'd0, ghr_o}, 32'd0);

        // Mispredict recovery: GHR taken from the head snapshot, FIFO flushed
        do_query(32'h80, 1'b0, "mis_x");
        do_update(1'b1, 1'b1, "mis_x");
        check("mis_x_ghr", {24'd0, ghr_o}, 32'h01);
        do_query(32'h80, 1'b0, "mis_a");
        do_query(32'h80, 1'b0, "mis_b");
        do_query(32'h80, 1'b0, "mis_c");
        check("mis_pre_ghr", {24'd0, ghr_o}, 32'h08);
        check("mis_pre_count", {29'd0, fifo_count_o}, 32'd3);
        query_valid  = 1'b1;
        query_pc     = 32'h80;
        update_valid = 1'b1;
        update_taken = 1'b1;
        #1;
        check("mis_ready_low", {31'd0, query_ready}, 32'd0);
        tick();
        query_valid  = 1'b0;
        update_valid = 1'b0;
        check("mis_flush", {29'd0, fifo_count_o}, 32'd0);
        check("mis_ghr", {24'd0, ghr_o}, 32'h03);
        check("mis_pulse", {31'd0, mispredict_o}, 32'd1);
        tick();
        check("mis_pulse_end", {31'd0, mispredict_o}, 32'd0);
        check("mis_post_count", {29'd0, fifo_count_o}, 32'd0);

        // Performance counters: 10 queries, 3 mispredicts after a fresh reset
        rst = 1'b1;
        repeat (2) tick();
        check("perf_rst_q", perf_query_cnt, 32'd0);
        check("perf_rst_m", perf_mispred_cnt, 32'd0);
        check("perf_rst_ghr", {24'd0, ghr_o}, 32'd0);
        rst = 1'b0;
        wait_ready(1024, "init2");
        do_query(32'h400, 1'b0, "perf_m1");
        do_update(1'b1, 1'b1, "perf_m1");
        do_query(32'h440, 1'b0, "perf_m2");
        do_update(1'b1, 1'b1, "perf_m2");
        do_query(32'h480, 1'b0, "perf_m3");
        do_update(1'b1, 1'b1, "perf_m3");
        check("perf_ghr_mid", {24'd0, ghr_o}, 32'h07);
        for (int k = 0; k < 7; k++) begin
            do_query(32'h800, 1'b0, "perf_ok");
            do_update(1'b0, 1'b0, "perf_ok");
        end
        check("perf_ghr_end", {24'd0, ghr_o}, 32'h80);
`ifdef GSHARE_PERF_CNT_EN
        check("perf_query", perf_query_cnt, 32'd10);
        check("perf_mispred", perf_mispred_cnt, 32'd3);
`else
        check("perf_query", perf_query_cnt, 32'd0);
        check("perf_mispred", perf_mispred_cnt, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
